// File: rtl/acl_spi_responder.sv
// acl_spi_responder: SPI mode-0 slave that stands in for an ADXL362 accelerometer.
// SCLK, CSN and MOSI are oversampled in the ClkPort domain. Tilt values come from
// x/y/z_data and are served through the normal register read path.
module acl_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        spi_sclk,
  input  logic        spi_csn,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        txn_done,
  output logic        err_cmd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD,
    S_WR,
    S_IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_csnSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sclkPrev;
  logic                   r_csnPrev;

  state_t      r_state;
  logic [2:0]  r_bitCnt;
  logic [6:0]  r_shift;
  logic        r_isRead;
  logic [7:0]  r_addr;
  logic [35:0] r_snap;

  logic        w_sclk;
  logic        w_csn;
  logic        w_mosi;
  logic        w_sclkRise;
  logic        w_sclkFall;
  logic        w_csnRise;
  logic        w_csnFall;
  logic [7:0]  w_byte;
  logic [7:0]  w_nextAddr;
  logic [11:0] w_x;
  logic [11:0] w_y;
  logic [11:0] w_z;
  logic [7:0]  w_rdData;

  // Synchronise the SPI pins and keep one extra sample of SCLK/CSN for edge detection;
  // CSN resets high so a deselected bus does not look like a falling edge.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_sclkSync <= '0;
      r_csnSync  <= '1;
      r_mosiSync <= '0;
      r_sclkPrev <= 1'b0;
      r_csnPrev  <= 1'b1;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk};
      r_csnSync  <= {r_csnSync[SYNC_STAGES-2:0], spi_csn};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
      r_sclkPrev <= r_sclkSync[SYNC_STAGES-1];
      r_csnPrev  <= r_csnSync[SYNC_STAGES-1];
    end
  end

  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_csn      = r_csnSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclk & ~r_sclkPrev;
  assign w_sclkFall = ~w_sclk & r_sclkPrev;
  assign w_csnRise  = w_csn & ~r_csnPrev;
  assign w_csnFall  = ~w_csn & r_csnPrev;
  assign w_byte     = {r_shift, w_mosi};
  assign w_nextAddr = {2'b00, r_addr[5:0] + 6'd1};

  assign w_x = r_snap[35:24];
  assign w_y = r_snap[23:12];
  assign w_z = r_snap[11:0];

  // Register map as seen by a read; data registers are sign-extended 12-bit samples.
  always_comb begin
    w_rdData = 8'h00;
    case (r_addr)
      8'h00:   w_rdData = DEVID_AD;
      8'h01:   w_rdData = DEVID_MST;
      8'h02:   w_rdData = PARTID;
      8'h03:   w_rdData = 8'h02;
      8'h08:   w_rdData = w_x[11:4];
      8'h09:   w_rdData = w_y[11:4];
      8'h0A:   w_rdData = w_z[11:4];
      8'h0E:   w_rdData = w_x[7:0];
      8'h0F:   w_rdData = {{4{w_x[11]}}, w_x[11:8]};
      8'h10:   w_rdData = w_y[7:0];
      8'h11:   w_rdData = {{4{w_y[11]}}, w_y[11:8]};
      8'h12:   w_rdData = w_z[7:0];
      8'h13:   w_rdData = {{4{w_z[11]}}, w_z[11:8]};
      8'h2C:   w_rdData = filter_ctl;
      8'h2D:   w_rdData = power_ctl;
      default: w_rdData = 8'h00;
    endcase
  end

  // Transaction FSM: CSN edges win over SCLK edges, bytes complete on the 8th rise,
  // and MISO only moves on SCLK falls so it is settled before the master samples it.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_bitCnt   <= 3'd0;
      r_shift    <= 7'd0;
      r_isRead   <= 1'b0;
      r_addr     <= 8'h00;
      r_snap     <= 36'd0;
      spi_miso   <= 1'b0;
      power_ctl  <= 8'h00;
      filter_ctl <= 8'h13;
      txn_done   <= 1'b0;
      err_cmd    <= 1'b0;
    end else begin
      txn_done <= 1'b0;
      err_cmd  <= 1'b0;
      if (w_csnRise) begin
        r_state  <= S_IDLE;
        r_bitCnt <= 3'd0;
        spi_miso <= 1'b0;
        if (r_state == S_ADDR || r_state == S_RD || r_state == S_WR) begin
          txn_done <= 1'b1;
        end else if (r_state == S_IGNORE) begin
          err_cmd <= 1'b1;
        end
      end else if (w_csnFall) begin
        r_state  <= S_CMD;
        r_bitCnt <= 3'd0;
        spi_miso <= 1'b0;
        r_snap   <= {x_data, y_data, z_data};
      end else if (r_state != S_IDLE && !w_csn) begin
        if (w_sclkRise) begin
          r_shift  <= w_byte[6:0];
          r_bitCnt <= r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            case (r_state)
              S_CMD: begin
                if (w_byte == CMD_READ) begin
                  r_isRead <= 1'b1;
                  r_state  <= S_ADDR;
                end else if (w_byte == CMD_WRITE) begin
                  r_isRead <= 1'b0;
                  r_state  <= S_ADDR;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
              S_ADDR: begin
                r_addr  <= w_byte;
                r_state <= r_isRead ? S_RD : S_WR;
              end
              S_RD: begin
                r_addr <= w_nextAddr;
              end
              S_WR: begin
                if (r_addr == 8'h2C) filter_ctl <= w_byte;
                if (r_addr == 8'h2D) power_ctl <= w_byte;
                r_addr <= w_nextAddr;
              end
              default: begin
              end
            endcase
          end
        end else if (w_sclkFall && r_state == S_RD) begin
          spi_miso <= w_rdData[3'd7 - r_bitCnt];
        end
      end
    end
  end

endmodule

// File: tb/tb_acl_spi_responder.sv
// tb_acl_spi_responder: drives the responder as an SPI mode-0 master and checks every
// returned byte, pulse and control register against a register-level model.
module tb_acl_spi_responder;

  localparam int HALF = 8;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic        spi_sclk;
  logic        spi_csn;
  logic        spi_mosi;
  logic        spi_miso;
  logic [11:0] x_data;
  logic [11:0] y_data;
  logic [11:0] z_data;
  logic [7:0]  power_ctl;
  logic [7:0]  filter_ctl;
  logic        txn_done;
  logic        err_cmd;

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  int errCnt = 0;
  bit quiet = 1'b0;

  logic [7:0] modelPower;
  logic [7:0] modelFilter;
  logic [7:0] txBuf [16];
  logic [7:0] rxBuf [16];

  acl_spi_responder dut (
    .ClkPort    (ClkPort),
    .Reset      (Reset),
    .spi_sclk   (spi_sclk),
    .spi_csn    (spi_csn),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .x_data     (x_data),
    .y_data     (y_data),
    .z_data     (z_data),
    .power_ctl  (power_ctl),
    .filter_ctl (filter_ctl),
    .txn_done   (txn_done),
    .err_cmd    (err_cmd)
  );

  always #5 ClkPort = ~ClkPort;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Register value a read must return, from the documented map and a snapshot.
  function automatic logic [7:0] modelRead(input logic [7:0] a, input logic [11:0] x,
                                           input logic [11:0] y, input logic [11:0] z);
    int xv, yv, zv;
    logic [15:0] xs, ys, zs;
    xv = (x >= 12'd2048) ? int'(x) - 4096 : int'(x);
    yv = (y >= 12'd2048) ? int'(y) - 4096 : int'(y);
    zv = (z >= 12'd2048) ? int'(z) - 4096 : int'(z);
    xs = 16'(xv);
    ys = 16'(yv);
    zs = 16'(zv);
    case (a)
      8'h00: return 8'hAD;
      8'h01: return 8'h1D;
      8'h02: return 8'hF2;
      8'h03: return 8'h02;
      8'h08: return 8'(x / 16);
      8'h09: return 8'(y / 16);
      8'h0A: return 8'(z / 16);
      8'h0E: return xs[7:0];
      8'h0F: return xs[15:8];
      8'h10: return ys[7:0];
      8'h11: return ys[15:8];
      8'h12: return zs[7:0];
      8'h13: return zs[15:8];
      8'h2C: return modelFilter;
      8'h2D: return modelPower;
      default: return 8'h00;
    endcase
  endfunction

  // Count pulses and continuously compare idle-time outputs against the model.
  always @(negedge ClkPort) begin
    if (txn_done === 1'b1) doneCnt++;
    if (err_cmd === 1'b1) errCnt++;
    if (!Reset) checkOutput("pulse_exclusive", 32'(txn_done & err_cmd), 32'd0);
    if (quiet) begin
      checkOutput("idle_power_ctl", 32'(power_ctl), 32'(modelPower));
      checkOutput("idle_filter_ctl", 32'(filter_ctl), 32'(modelFilter));
      checkOutput("idle_miso", 32'(spi_miso), 32'd0);
    end
  end

  task automatic sendBit(input logic b, output logic sampled);
    spi_mosi = b;
    repeat (HALF) @(negedge ClkPort);
    spi_sclk = 1'b1;
    sampled = spi_miso;
    repeat (HALF) @(negedge ClkPort);
    spi_sclk = 1'b0;
  endtask

  // One CSN-framed transfer of nBytes whole bytes plus extraBits of txBuf[nBytes];
  // the sensor inputs change after the address byte to prove the snapshot holds.
  task automatic applyStimulus(input int nBytes, input int extraBits);
    logic s;
    quiet = 1'b0;
    @(negedge ClkPort);
    spi_sclk = 1'b0;
    spi_csn = 1'b0;
    repeat (HALF) @(negedge ClkPort);
    for (int i = 0; i < nBytes; i++) begin
      for (int b = 7; b >= 0; b--) begin
        sendBit(txBuf[i][b], s);
        rxBuf[i][b] = s;
      end
      if (i == 1) begin
        x_data = 12'($urandom);
        y_data = 12'($urandom);
        z_data = 12'($urandom);
      end
    end
    for (int e = 0; e < extraBits; e++) sendBit(txBuf[nBytes][7-e], s);
    repeat (HALF) @(negedge ClkPort);
    spi_csn = 1'b1;
    repeat (10) @(negedge ClkPort);
  endtask

  task automatic runTxn(input int nBytes, input int extraBits);
    int d0, e0;
    logic [11:0] sx, sy, sz;
    logic [7:0] a, expByte;
    bit isRd, isWr;
    d0 = doneCnt;
    e0 = errCnt;
    sx = x_data;
    sy = y_data;
    sz = z_data;
    isRd = (txBuf[0] == 8'h0B);
    isWr = (txBuf[0] == 8'h0A);
    applyStimulus(nBytes, extraBits);
    checkOutput("txn_done_count", 32'(doneCnt - d0), 32'((nBytes >= 1 && (isRd || isWr)) ? 1 : 0));
    checkOutput("err_cmd_count", 32'(errCnt - e0), 32'((nBytes >= 1 && !(isRd || isWr)) ? 1 : 0));
    a = txBuf[1];
    for (int i = 0; i < nBytes; i++) begin
      expByte = 8'h00;
      if (i >= 2) begin
        if (isRd) expByte = modelRead(a, sx, sy, sz);
        if (isWr && a == 8'h2C) modelFilter = txBuf[i];
        if (isWr && a == 8'h2D) modelPower = txBuf[i];
        a = (a + 8'd1) & 8'h3F;
      end
      checkOutput($sformatf("miso_byte%0d", i), 32'(rxBuf[i]), 32'(expByte));
    end
    quiet = 1'b1;
    repeat (4) @(negedge ClkPort);
  endtask

  task automatic setTx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    txBuf[0] = b0; txBuf[1] = b1; txBuf[2] = b2;
    txBuf[3] = b3; txBuf[4] = b4; txBuf[5] = b5;
  endtask

  initial begin
    logic s;
    logic [7:0] cmd;
    int nB, ex;
    Reset = 1'b1;
    spi_sclk = 1'b0;
    spi_csn = 1'b1;
    spi_mosi = 1'b0;
    x_data = 12'h000;
    y_data = 12'h000;
    z_data = 12'h000;
    modelPower = 8'h00;
    modelFilter = 8'h13;
    repeat (3) @(negedge ClkPort);
    checkOutput("reset_miso", 32'(spi_miso), 32'd0);
    checkOutput("reset_power_ctl", 32'(power_ctl), 32'h00);
    checkOutput("reset_filter_ctl", 32'(filter_ctl), 32'h13);
    checkOutput("reset_txn_done", 32'(txn_done), 32'd0);
    checkOutput("reset_err_cmd", 32'(err_cmd), 32'd0);
    Reset = 1'b0;
    repeat (5) @(negedge ClkPort);
    quiet = 1'b1;

    // ID registers in one burst
    setTx(8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    runTxn(5, 0);
    checkOutput("id_devid_ad", 32'(rxBuf[2]), 32'hAD);
    checkOutput("id_devid_mst", 32'(rxBuf[3]), 32'h1D);
    checkOutput("id_partid", 32'(rxBuf[4]), 32'hF2);

    // Sign-extended data burst; inputs are scrambled after the address byte
    x_data = 12'hF85;
    y_data = 12'h7FF;
    z_data = 12'h123;
    setTx(8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00);
    txBuf[6] = 8'h00;
    txBuf[7] = 8'h00;
    runTxn(8, 0);
    checkOutput("xdata_l", 32'(rxBuf[2]), 32'h85);
    checkOutput("xdata_h", 32'(rxBuf[3]), 32'hFF);
    checkOutput("ydata_h", 32'(rxBuf[5]), 32'h07);
    checkOutput("zdata_l", 32'(rxBuf[6]), 32'h23);
    checkOutput("zdata_h", 32'(rxBuf[7]), 32'h01);

    // Write power_ctl and read it back
    setTx(8'h0A, 8'h2D, 8'h02, 8'h00, 8'h00, 8'h00);
    runTxn(3, 0);
    checkOutput("write_power_ctl", 32'(power_ctl), 32'h02);
    setTx(8'h0B, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00);
    runTxn(3, 0);
    checkOutput("readback_power_ctl", 32'(rxBuf[2]), 32'h02);

    // Unknown command is ignored
    setTx(8'h55, 8'h2D, 8'hFF, 8'hFF, 8'h00, 8'h00);
    runTxn(4, 0);
    checkOutput("ignore_power_ctl", 32'(power_ctl), 32'h02);

    // Partial data byte is discarded
    setTx(8'h0A, 8'h2D, 8'hF0, 8'h00, 8'h00, 8'h00);
    runTxn(2, 4);
    checkOutput("partial_power_ctl", 32'(power_ctl), 32'h02);

    // Reset in the middle of a read
    quiet = 1'b0;
    setTx(8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge ClkPort);
    spi_csn = 1'b0;
    repeat (HALF) @(negedge ClkPort);
    for (int i = 0; i < 2; i++)
      for (int b = 7; b >= 0; b--) sendBit(txBuf[i][b], s);
    repeat (6) @(negedge ClkPort);
    checkOutput("miso_before_reset", 32'(spi_miso), 32'd1);
    Reset = 1'b1;
    #1;
    checkOutput("miso_in_reset", 32'(spi_miso), 32'd0);
    checkOutput("power_in_reset", 32'(power_ctl), 32'h00);
    spi_csn = 1'b1;
    repeat (4) @(negedge ClkPort);
    Reset = 1'b0;
    modelPower = 8'h00;
    modelFilter = 8'h13;
    repeat (10) @(negedge ClkPort);
    quiet = 1'b1;
    setTx(8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    runTxn(3, 0);
    checkOutput("after_reset_devid", 32'(rxBuf[2]), 32'hAD);

    // Randomised transactions
    for (int t = 0; t < 30; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) cmd = 8'h0B;
      else if (r < 80) cmd = 8'h0A;
      else begin
        cmd = 8'($urandom);
        if (cmd == 8'h0A || cmd == 8'h0B) cmd = cmd ^ 8'h80;
      end
      txBuf[0] = cmd;
      r = $urandom_range(0, 7);
      case (r)
        0: txBuf[1] = 8'h2C;
        1: txBuf[1] = 8'h2D;
        2: txBuf[1] = 8'h3E;
        3: txBuf[1] = 8'($urandom);
        default: txBuf[1] = 8'($urandom_range(0, 63));
      endcase
      for (int i = 2; i < 16; i++) txBuf[i] = 8'($urandom);
      nB = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 6);
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      x_data = 12'($urandom);
      y_data = 12'($urandom);
      z_data = 12'($urandom);
      runTxn(nB, ex);
    end

    quiet = 1'b0;
    repeat (5) @(negedge ClkPort);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
